// File: rtl/store_merge_pkg.sv
// Shared encodings for store_merge_ctrl: FSM states, request size codes and lane widths.
package store_merge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    localparam int unsigned ByteW = 8;
    localparam int unsigned HalfW = 16;
    localparam int unsigned WordW = 32;

endpackage

// File: rtl/byte_lane_merge.sv
// Combinational lane extract (zero-extended) and lane merge for one 32-bit word.
// Half and word accesses always align down: low lane bits beyond the access size are ignored.
module byte_lane_merge
    import store_merge_pkg::*;
(
    input  logic [WordW-1:0] word_i,
    input  logic [WordW-1:0] wdata_i,
    input  size_e            size_i,
    input  logic [1:0]       lane_i,
    output logic [WordW-1:0] rdata_o,
    output logic [WordW-1:0] merged_o
);

    logic [4:0] byte_sh;
    logic [4:0] half_sh;

    assign byte_sh = {lane_i, 3'b000};
    assign half_sh = {lane_i[1], 4'b0000};

    always_comb begin
        rdata_o  = '0;
        merged_o = word_i;
        case (size_i)
            SZ_BYTE: begin
                rdata_o[ByteW-1:0]          = word_i[byte_sh +: ByteW];
                merged_o[byte_sh +: ByteW]  = wdata_i[ByteW-1:0];
            end
            SZ_HALF: begin
                rdata_o[HalfW-1:0]          = word_i[half_sh +: HalfW];
                merged_o[half_sh +: HalfW]  = wdata_i[HalfW-1:0];
            end
            SZ_WORD: begin
                rdata_o  = word_i;
                merged_o = wdata_i;
            end
            default: begin
                rdata_o  = '0;
                merged_o = word_i;
            end
        endcase
    end

endmodule

// File: rtl/store_merge_ctrl.sv
// Read-modify-write controller for a bank of 32-bit tristate registers on a shared bus.
// Optional macro STORE_MERGE_MISALIGN_CHECK_EN rejects misaligned half/word accesses.
//   state    | meaning
//   ST_IDLE  | ready for a request
//   ST_READ  | one register drives RegQ, word captured at end of cycle
//   ST_WRITE | merged word on RegD, RegEn pulses for the target register
//   ST_RESP  | response held until consumed
module store_merge_ctrl
    import store_merge_pkg::*;
#(
    parameter int NrOfRegs = 8,
    parameter int IdxBits  = 3
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Tick,
    input  logic                ReqValid,
    output logic                ReqReady,
    input  logic                ReqWrite,
    input  logic [31:0]         ReqAddr,
    input  logic [1:0]          ReqSize,
    input  logic [31:0]         ReqWData,
    output logic                RspValid,
    input  logic                RspReady,
    output logic [31:0]         RspRData,
    output logic                RspErr,
    output logic [NrOfRegs-1:0] RegCs,
    output logic [NrOfRegs-1:0] RegEn,
    output logic [31:0]         RegD,
    input  logic [31:0]         RegQ
);

    localparam logic [NrOfRegs-1:0] OneHot0 = NrOfRegs'(1);

    state_e                state_q, state_d;
    logic                  ready_q, ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [31:0]           rsp_rdata_q, rsp_rdata_d;
    logic [NrOfRegs-1:0]   reg_cs_q, reg_cs_d;
    logic [NrOfRegs-1:0]   reg_en_q, reg_en_d;
    logic [31:0]           reg_d_q, reg_d_d;
    logic                  write_q, write_d;
    logic [IdxBits-1:0]    idx_q, idx_d;
    size_e                 size_q, size_d;
    logic [1:0]            lane_q, lane_d;
    logic [31:0]           wdata_q, wdata_d;

    logic [IdxBits-1:0]    req_idx;
    logic                  req_misalign;
    logic                  req_illegal;
    logic [31:0]           lane_rdata;
    logic [31:0]           lane_merged;
    logic                  addr_hi_unused;

    assign req_idx        = ReqAddr[IdxBits+1:2];
    assign addr_hi_unused = ^ReqAddr[31:IdxBits+2];

`ifdef STORE_MERGE_MISALIGN_CHECK_EN
    assign req_misalign = ((ReqSize == SZ_HALF) && ReqAddr[0]) ||
                          ((ReqSize == SZ_WORD) && (ReqAddr[1:0] != 2'b00));
`else
    assign req_misalign = 1'b0;
`endif

    assign req_illegal = (ReqSize == SZ_RSVD) || req_misalign ||
                         ({1'b0, req_idx} >= (IdxBits+1)'(NrOfRegs));

    // Fed straight from the bus: results are only consumed while in ST_READ.
    byte_lane_merge u_lane (
        .word_i   (RegQ),
        .wdata_i  (wdata_q),
        .size_i   (size_q),
        .lane_i   (lane_q),
        .rdata_o  (lane_rdata),
        .merged_o (lane_merged)
    );

    always_comb begin
        state_d     = state_q;
        ready_d     = ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        reg_cs_d    = reg_cs_q;
        reg_en_d    = reg_en_q;
        reg_d_d     = reg_d_q;
        write_d     = write_q;
        idx_d       = idx_q;
        size_d      = size_q;
        lane_d      = lane_q;
        wdata_d     = wdata_q;
        if (Tick) begin
            reg_en_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (ReqValid && ready_q) begin
                        write_d = ReqWrite;
                        idx_d   = req_idx;
                        size_d  = size_e'(ReqSize);
                        lane_d  = ReqAddr[1:0];
                        wdata_d = ReqWData;
                        ready_d = 1'b0;
                        if (req_illegal) begin
                            state_d     = ST_RESP;
                            rsp_valid_d = 1'b1;
                            rsp_err_d   = 1'b1;
                            rsp_rdata_d = '0;
                        end else begin
                            state_d  = ST_READ;
                            reg_cs_d = ~(OneHot0 << req_idx);
                        end
                    end
                end
                ST_READ: begin
                    reg_cs_d  = '1;
                    rsp_err_d = 1'b0;
                    if (write_q) begin
                        state_d     = ST_WRITE;
                        reg_d_d     = lane_merged;
                        reg_en_d    = OneHot0 << idx_q;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = lane_rdata;
                    end
                end
                ST_WRITE: begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                end
                ST_RESP: begin
                    if (RspReady) begin
                        state_d     = ST_IDLE;
                        rsp_valid_d = 1'b0;
                        ready_d     = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            reg_cs_q    <= '1;
            reg_en_q    <= '0;
            reg_d_q     <= '0;
            write_q     <= 1'b0;
            idx_q       <= '0;
            size_q      <= SZ_BYTE;
            lane_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            reg_cs_q    <= reg_cs_d;
            reg_en_q    <= reg_en_d;
            reg_d_q     <= reg_d_d;
            write_q     <= write_d;
            idx_q       <= idx_d;
            size_q      <= size_d;
            lane_q      <= lane_d;
            wdata_q     <= wdata_d;
        end
    end

    assign ReqReady = ready_q;
    assign RspValid = rsp_valid_q;
    assign RspErr   = rsp_err_q;
    assign RspRData = rsp_rdata_q;
    assign RegCs    = reg_cs_q;
    assign RegD     = reg_d_q;
    // The write strobe must never reach a register on a frozen or resetting cycle.
    assign RegEn    = reg_en_q & {NrOfRegs{Tick & ~Reset}};

endmodule

// File: doc/store_merge_ctrl.md
STORE_MERGE_CTRL -- requirements
Module: store_merge_ctrl

Interface
REQ-001 SHALL have parameter NrOfRegs, default 8, giving the number of 32-bit tristate registers on the shared bus (power of two, 2..32).
REQ-002 SHALL have parameter IdxBits, default 3, equal to log2(NrOfRegs) and giving the word-index width.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 Clock  input  1  single clock, all state updates on rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 Tick  input  1  global advance enable; FSM and registers update only when Tick=1.
REQ-007 ReqValid  input  1  request present.
REQ-008 ReqReady  output  1  block accepts a request (IDLE only).
REQ-009 ReqWrite  input  1  1=store, 0=load.
REQ-010 ReqAddr  input  32  byte address; word index = ReqAddr[IdxBits+1:2].
REQ-011 ReqSize  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-012 ReqWData  input  32  store data, right-aligned.
REQ-013 RspValid  output  1  response present.
REQ-014 RspReady  input  1  consumer takes the response.
REQ-015 RspRData  output  32  load data, selected lane zero-extended to bit 0.
REQ-016 RspErr  output  1  request rejected, no register modified.
REQ-017 RegCs  output  NrOfRegs  per-register output disable; 1 = Q high-Z, at most one bit 0.
REQ-018 RegEn  output  NrOfRegs  per-register clock enable, at most one bit 1.
REQ-019 RegD  output  32  shared write data to all registers.
REQ-020 RegQ  input  32  shared tristate read bus.

Function
REQ-021 FSM states IDLE, READ, WRITE, RESP; transitions occur only on edges with Tick=1.
REQ-022 IDLE: handshake ReqValid&ReqReady&Tick latches the request; legal -> READ, illegal -> RESP with RspErr=1.
REQ-023 Illegal: ReqSize=11, or word index >= NrOfRegs (not reachable when NrOfRegs=2^IdxBits), or misalignment per REQ-036.
REQ-024 READ: RegCs[idx]=0 for exactly one cycle; RegQ is captured at the end of that cycle; load -> RESP, store -> WRITE.
REQ-025 WRITE: RegD = captured word with the addressed byte/half/word lane replaced by ReqWData low bits; RegEn[idx]=1 for one Tick cycle; -> RESP.
REQ-026 RESP: RspValid=1; RspRData/RspErr held stable until RspValid&RspReady&Tick, then -> IDLE.
REQ-027 Latency from accept to RspValid: error 1, load 2, store 3 Tick cycles.
REQ-028 Store response SHALL carry RspRData=0 and RspErr=0.
REQ-029 Tick=0 SHALL freeze state and all registered outputs; RegEn forced to all 0.
REQ-030 Byte lane = ReqAddr[1:0]; half lane = ReqAddr[1]; no sign extension.
REQ-031 RegCs all 1 and RegEn all 0 in every state except as stated in REQ-024/REQ-025.

Reset
REQ-032 Reset=1 on a rising edge SHALL force IDLE regardless of Tick.
REQ-033 Reset values: ReqReady=1, RspValid=0, RspRData=0, RspErr=0, RegCs all 1, RegEn all 0, RegD=0.
REQ-034 Reset asserted in READ or WRITE SHALL abort with no register written and no response issued.
REQ-035 RegEn SHALL be 0 throughout any cycle in which Reset=1.

Configuration
REQ-036 Macro STORE_MERGE_MISALIGN_CHECK_EN defined: a half access at ReqAddr[0]=1 or a word access at ReqAddr[1:0]!=0 is illegal (RspErr=1); undefined: the offending low address bits are ignored and the access proceeds aligned down.

Structure
REQ-037 Package store_merge_pkg SHALL hold the FSM state encoding, the ReqSize codes and the lane-width constants.
REQ-038 Lane extract/merge SHALL be a combinational sub-module byte_lane_merge, instantiated once.

Verification
REQ-039 Reg2=0x11223344, store byte 0xAA to addr 0x09 -> RegEn[2] pulses once, RegD=0x1122AA44, RspValid 3 cycles after accept.
REQ-040 Reg5=0xDEADBEEF, load half addr 0x16 -> RegCs[5]=0 for one cycle, RspRData=0x0000DEAD after 2 cycles.
REQ-041 ReqSize=11 -> RspErr=1 after 1 cycle, RegCs all 1, RegEn all 0 throughout.
REQ-042 Word store to addr 0x06: with macro -> RspErr=1, no write; without macro -> Reg1 fully written.
REQ-043 Reset asserted in WRITE state -> RegEn stays 0, state IDLE, RspValid=0, target register unchanged.
REQ-044 Tick=0 for 4 cycles during RESP with RspReady=1 -> RspValid and data held, no transition until Tick=1.
